// File: rtl/mem_access_if.sv
// MEM-stage access bundle: pipeline request side, RAM req/ack bus and status back to the pipeline.
// master = the access unit, slave = the pipeline/RAM environment around it.
interface mem_access_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int NB = DATA_W / 8;

    logic              flush;
    logic              req_valid;
    logic              req_write;
    logic              req_sign_ext;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              ram_req;
    logic [NB-1:0]     ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_ack;
    logic [DATA_W-1:0] ram_rdata;

    logic              stall_req;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              addr_err_load;
    logic              addr_err_store;
    logic              timeout_err;

    modport master (
        input  flush, req_valid, req_write, req_sign_ext, req_size, req_addr, req_wdata,
        input  ram_ack, ram_rdata,
        output ram_req, ram_we, ram_addr, ram_wdata,
        output stall_req, load_valid, load_data, addr_err_load, addr_err_store, timeout_err
    );

    modport slave (
        output flush, req_valid, req_write, req_sign_ext, req_size, req_addr, req_wdata,
        output ram_ack, ram_rdata,
        input  ram_req, ram_we, ram_addr, ram_wdata,
        input  stall_req, load_valid, load_data, addr_err_load, addr_err_store, timeout_err
    );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle MEM-stage RAM access: aligns stores, extracts/extends loads, stalls until ack,
// flags misalignment and bus timeout.

// One byte lane: store byte-enable/data steering and load byte selection with extension fill.
module mem_access_lane #(
    parameter int NB   = 4,
    parameter int LANE = 0,
    parameter int OFFW = 2
) (
    input  logic [OFFW-1:0]    st_off,
    input  logic [3:0]         st_nbytes,
    input  logic [NB-1:0][7:0] st_data,
    input  logic [OFFW-1:0]    ld_off,
    input  logic [3:0]         ld_nbytes,
    input  logic               ld_fill,
    input  logic [NB-1:0][7:0] ld_data,
    output logic               we,
    output logic [7:0]         wbyte,
    output logic [7:0]         lbyte
);
    always_comb begin
        we    = (LANE >= int'(st_off)) && (LANE < int'(st_off) + int'(st_nbytes));
        wbyte = '0;
        for (int j = 0; j < NB; j++)
            if (j + int'(st_off) == LANE) wbyte = st_data[j];
        // Lanes above the access size take the extension bit instead of RAM data.
        lbyte = {8{ld_fill}};
        if (LANE < int'(ld_nbytes))
            for (int j = 0; j < NB; j++)
                if (j == int'(ld_off) + LANE) lbyte = ld_data[j];
    end
endmodule

module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic         clk,
    input logic         rst,
    mem_access_if.master bus
);
    localparam int NB    = DATA_W / 8;
    localparam int OFFW  = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 ram_req_r;
    logic [NB-1:0]        ram_we_r;
    logic [ADDR_W-1:0]    ram_addr_r;
    logic [DATA_W-1:0]    ram_wdata_r;
    logic                 load_valid_r;
    logic [DATA_W-1:0]    load_data_r;
    logic                 timeout_err_r;
    logic                 lat_write;
    logic                 lat_sign;
    logic [OFFW-1:0]      lat_off;
    logic [3:0]           lat_nbytes;

    logic [OFFW-1:0]      req_off;
    logic [3:0]           req_nbytes;
    logic                 misaligned;
    logic                 accept;
    logic                 sign_bit;
    logic                 ld_fill;
    logic [NB-1:0]        st_we;
    logic [NB-1:0][7:0]   wd_bytes, rd_bytes, st_bytes, ld_bytes;

    assign req_off    = bus.req_addr[OFFW-1:0];
    assign req_nbytes = 4'd1 << bus.req_size;
    // Size larger than the bus (dword on a 32-bit bus) counts as misaligned.
    assign misaligned = (int'(req_nbytes) > NB) ||
                        ((int'(req_off) & (int'(req_nbytes) - 1)) != 0);
    assign accept     = (state == IDLE) && bus.req_valid && !misaligned && !bus.flush;

    assign wd_bytes = bus.req_wdata;
    assign rd_bytes = bus.ram_rdata;

    always_comb begin
        sign_bit = 1'b0;
        for (int j = 0; j < NB; j++)
            if (j == int'(lat_off) + int'(lat_nbytes) - 1) sign_bit = rd_bytes[j][7];
        ld_fill = lat_sign & sign_bit;
    end

    for (genvar i = 0; i < NB; i++) begin : g_lane
        mem_access_lane #(.NB(NB), .LANE(i), .OFFW(OFFW)) u_lane (
            .st_off    (req_off),
            .st_nbytes (req_nbytes),
            .st_data   (wd_bytes),
            .ld_off    (lat_off),
            .ld_nbytes (lat_nbytes),
            .ld_fill   (ld_fill),
            .ld_data   (rd_bytes),
            .we        (st_we[i]),
            .wbyte     (st_bytes[i]),
            .lbyte     (ld_bytes[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            ram_req_r     <= 1'b0;
            ram_we_r      <= '0;
            ram_addr_r    <= '0;
            ram_wdata_r   <= '0;
            load_valid_r  <= 1'b0;
            load_data_r   <= '0;
            timeout_err_r <= 1'b0;
            lat_write     <= 1'b0;
            lat_sign      <= 1'b0;
            lat_off       <= '0;
            lat_nbytes    <= '0;
        end else begin
            load_valid_r  <= 1'b0;
            timeout_err_r <= 1'b0;
            if (bus.flush) begin
                // Flush beats ack and timeout: drop the access silently.
                state     <= IDLE;
                ram_req_r <= 1'b0;
                ram_we_r  <= '0;
                cnt       <= '0;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        state       <= BUSY;
                        cnt         <= '0;
                        ram_req_r   <= 1'b1;
                        ram_we_r    <= bus.req_write ? st_we : '0;
                        ram_addr_r  <= {bus.req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
                        ram_wdata_r <= st_bytes;
                        lat_write   <= bus.req_write;
                        lat_sign    <= bus.req_sign_ext;
                        lat_off     <= req_off;
                        lat_nbytes  <= req_nbytes;
                    end
                    BUSY: begin
                        if (bus.ram_ack) begin
                            state     <= DONE;
                            ram_req_r <= 1'b0;
                            ram_we_r  <= '0;
                            if (!lat_write) begin
                                load_valid_r <= 1'b1;
                                load_data_r  <= ld_bytes;
                            end
                        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                            state         <= ERR;
                            ram_req_r     <= 1'b0;
                            ram_we_r      <= '0;
                            timeout_err_r <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    DONE:    state <= IDLE;
                    ERR:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.ram_req        = ram_req_r;
    assign bus.ram_we         = ram_we_r;
    assign bus.ram_addr       = ram_addr_r;
    assign bus.ram_wdata      = ram_wdata_r;
    assign bus.load_valid     = load_valid_r;
    assign bus.load_data      = load_data_r;
    assign bus.timeout_err    = timeout_err_r;
    assign bus.stall_req      = accept || (state == BUSY);
    assign bus.addr_err_load  = (state == IDLE) && bus.req_valid && misaligned && !bus.req_write;
    assign bus.addr_err_store = (state == IDLE) && bus.req_valid && misaligned && bus.req_write;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table for single accesses, hand sequences for
// timeout, flush, stray ack, async reset and a 64-bit instance.
module tb_mem_access_unit;
    logic clk, rst;
    int checks = 0;
    int errors = 0;

    mem_access_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_access_if #(.ADDR_W(32), .DATA_W(64)) b64 ();

    mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    mem_access_unit #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(8)) dut64 (.clk(clk), .rst(rst), .bus(b64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    typedef struct {
        logic        wr;
        logic        sx;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          k;
        logic        err;
        logic [3:0]  we;
        logic [31:0] waddr;
        logic [31:0] wdat;
        logic [31:0] ldata;
    } vec_t;

    vec_t v[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, act, exp);
        end
    endtask

    task automatic issue32(input logic wr, input logic sx, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_sign_ext = sx;
        bus.req_size     = sz;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
    endtask

    initial begin
        //       wr  sx  sz    addr          wdata         rdata        k  err we       waddr         wdat          ldata
        v[0]  = '{0, 1, 2'd1, 32'h0000_2002, 32'h0,        32'h80FF1234, 3, 0, 4'b0000, 32'h0000_2000, 32'h0,        32'hFFFF80FF};
        v[1]  = '{1, 0, 2'd0, 32'h0000_1003, 32'h0000_00AB, 32'h0,       2, 0, 4'b1000, 32'h0000_1000, 32'hAB000000, 32'hFFFF80FF};
        v[2]  = '{0, 0, 2'd1, 32'h0000_2002, 32'h0,        32'h80FF1234, 3, 0, 4'b0000, 32'h0000_2000, 32'h0,        32'h000080FF};
        v[3]  = '{0, 1, 2'd2, 32'h0000_2001, 32'h0,        32'h0,        1, 1, 4'b0000, 32'h0,         32'h0,        32'h0};
        v[4]  = '{1, 0, 2'd1, 32'h0000_3001, 32'h0000_5678, 32'h0,       1, 1, 4'b0000, 32'h0,         32'h0,        32'h0};
        v[5]  = '{0, 1, 2'd0, 32'h0000_4001, 32'h0,        32'h12348056, 1, 0, 4'b0000, 32'h0000_4000, 32'h0,        32'hFFFFFF80};
        v[6]  = '{0, 0, 2'd0, 32'h0000_4003, 32'h0,        32'hC3000000, 2, 0, 4'b0000, 32'h0000_4000, 32'h0,        32'h000000C3};
        v[7]  = '{1, 0, 2'd2, 32'h0000_5000, 32'hDEADBEEF, 32'h0,        4, 0, 4'b1111, 32'h0000_5000, 32'hDEADBEEF, 32'h000000C3};
        v[8]  = '{1, 0, 2'd1, 32'h0000_6002, 32'h1234ABCD, 32'h0,        1, 0, 4'b1100, 32'h0000_6000, 32'hABCD0000, 32'h000000C3};
        v[9]  = '{0, 1, 2'd2, 32'h0000_7000, 32'h0,        32'h89ABCDEF, 2, 0, 4'b0000, 32'h0000_7000, 32'h0,        32'h89ABCDEF};
        v[10] = '{0, 0, 2'd3, 32'h0000_8000, 32'h0,        32'h0,        1, 1, 4'b0000, 32'h0,         32'h0,        32'h0};
        v[11] = '{0, 0, 2'd1, 32'h0000_2000, 32'h0,        32'h80FF1234, 1, 0, 4'b0000, 32'h0000_2000, 32'h0,        32'h00001234};

        rst = 1'b1;
        bus.flush = 0; bus.req_valid = 0; bus.req_write = 0; bus.req_sign_ext = 0;
        bus.req_size = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.ram_ack = 0; bus.ram_rdata = 0;
        b64.flush = 0; b64.req_valid = 0; b64.req_write = 0; b64.req_sign_ext = 0;
        b64.req_size = 0; b64.req_addr = 0; b64.req_wdata = 0; b64.ram_ack = 0; b64.ram_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst ram_req", bus.ram_req, 0);
        chk("rst ram_we", bus.ram_we, 0);
        chk("rst ram_addr", bus.ram_addr, 0);
        chk("rst ram_wdata", bus.ram_wdata, 0);
        chk("rst load_valid", bus.load_valid, 0);
        chk("rst load_data", bus.load_data, 0);
        chk("rst timeout_err", bus.timeout_err, 0);
        chk("rst stall", bus.stall_req, 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            issue32(v[i].wr, v[i].sx, v[i].sz, v[i].addr, v[i].wdata);
            #1;
            chk($sformatf("v%0d stall_issue", i), bus.stall_req, !v[i].err);
            chk($sformatf("v%0d addr_err_load", i), bus.addr_err_load, v[i].err & !v[i].wr);
            chk($sformatf("v%0d addr_err_store", i), bus.addr_err_store, v[i].err & v[i].wr);
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (v[i].err) begin
                #1;
                chk($sformatf("v%0d no_req", i), bus.ram_req, 0);
                chk($sformatf("v%0d no_we", i), bus.ram_we, 0);
            end else begin
                for (int c = 1; c <= v[i].k; c++) begin
                    if (c > 1) @(negedge clk);
                    bus.ram_ack   = (c == v[i].k);
                    bus.ram_rdata = v[i].rdata;
                    #1;
                    chk($sformatf("v%0d c%0d ram_req", i, c), bus.ram_req, 1);
                    chk($sformatf("v%0d c%0d stall", i, c), bus.stall_req, 1);
                    if (c == 1) begin
                        chk($sformatf("v%0d ram_we", i), bus.ram_we, v[i].we);
                        chk($sformatf("v%0d ram_addr", i), bus.ram_addr, v[i].waddr);
                        chk($sformatf("v%0d ram_wdata", i), bus.ram_wdata, v[i].wdat);
                    end
                end
                @(negedge clk);
                bus.ram_ack = 1'b0;
                #1;
                chk($sformatf("v%0d load_valid", i), bus.load_valid, !v[i].wr);
                chk($sformatf("v%0d done_stall", i), bus.stall_req, 0);
                chk($sformatf("v%0d done_req", i), bus.ram_req, 0);
                chk($sformatf("v%0d load_data", i), bus.load_data, v[i].ldata);
                @(negedge clk);
                #1;
                chk($sformatf("v%0d load_valid_drop", i), bus.load_valid, 0);
            end
        end

        // Timeout: no ack, TIMEOUT=4.
        @(negedge clk);
        issue32(0, 0, 2'd2, 32'h0000_9000, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            #1;
            chk($sformatf("to c%0d ram_req", c), bus.ram_req, 1);
            chk($sformatf("to c%0d timeout_err", c), bus.timeout_err, 0);
        end
        @(negedge clk);
        #1;
        chk("to timeout_err", bus.timeout_err, 1);
        chk("to ram_req", bus.ram_req, 0);
        chk("to stall", bus.stall_req, 0);
        chk("to load_valid", bus.load_valid, 0);
        @(negedge clk);
        #1;
        chk("to timeout_err_drop", bus.timeout_err, 0);

        // Flush in BUSY with ack in the same cycle.
        @(negedge clk);
        issue32(0, 1, 2'd2, 32'h0000_A000, 32'h0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.flush = 1'b1; bus.ram_ack = 1'b1; bus.ram_rdata = 32'h5555_5555;
        @(negedge clk);
        bus.flush = 1'b0; bus.ram_ack = 1'b0;
        #1;
        chk("fl load_valid", bus.load_valid, 0);
        chk("fl ram_req", bus.ram_req, 0);
        chk("fl stall", bus.stall_req, 0);
        chk("fl load_data_held", bus.load_data, 32'h0000_1234);
        chk("fl timeout_err", bus.timeout_err, 0);

        // Flush in IDLE blocks an aligned request.
        @(negedge clk);
        issue32(0, 0, 2'd2, 32'h0000_B000, 32'h0);
        bus.flush = 1'b1;
        #1;
        chk("fli stall", bus.stall_req, 0);
        @(negedge clk);
        bus.req_valid = 1'b0; bus.flush = 1'b0;
        #1;
        chk("fli ram_req", bus.ram_req, 0);

        // Stray ack while IDLE.
        @(negedge clk);
        bus.ram_ack = 1'b1; bus.ram_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.ram_ack = 1'b0;
        #1;
        chk("stray load_valid", bus.load_valid, 0);
        chk("stray load_data", bus.load_data, 32'h0000_1234);

        // Asynchronous reset in the middle of BUSY.
        @(negedge clk);
        issue32(1, 0, 2'd2, 32'h0000_C000, 32'h1122_3344);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk("ar ram_req_before", bus.ram_req, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar ram_req", bus.ram_req, 0);
        chk("ar ram_we", bus.ram_we, 0);
        chk("ar stall", bus.stall_req, 0);
        chk("ar load_data", bus.load_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // 64-bit bus: word store in upper half, misaligned and aligned dword loads.
        @(negedge clk);
        b64.req_valid = 1'b1; b64.req_write = 1'b1; b64.req_sign_ext = 1'b0;
        b64.req_size = 2'd2; b64.req_addr = 32'h0000_1004; b64.req_wdata = 64'h0000_0000_CAFE_F00D;
        #1;
        chk("w64 stall", b64.stall_req, 1);
        @(negedge clk);
        b64.req_valid = 1'b0; b64.ram_ack = 1'b1;
        #1;
        chk("w64 ram_we", b64.ram_we, 8'hF0);
        chk("w64 ram_wdata", b64.ram_wdata, 64'hCAFE_F00D_0000_0000);
        chk("w64 ram_addr", b64.ram_addr, 32'h0000_1000);
        @(negedge clk);
        b64.ram_ack = 1'b0;
        @(negedge clk);
        b64.req_valid = 1'b1; b64.req_write = 1'b0; b64.req_sign_ext = 1'b1;
        b64.req_size = 2'd3; b64.req_addr = 32'h0000_1004;
        #1;
        chk("d64 mis addr_err_load", b64.addr_err_load, 1);
        chk("d64 mis stall", b64.stall_req, 0);
        @(negedge clk);
        b64.req_addr = 32'h0000_1008;
        #1;
        chk("d64 ok addr_err_load", b64.addr_err_load, 0);
        chk("d64 ok stall", b64.stall_req, 1);
        @(negedge clk);
        b64.req_valid = 1'b0; b64.ram_ack = 1'b1; b64.ram_rdata = 64'h8123_4567_89AB_CDEF;
        @(negedge clk);
        b64.ram_ack = 1'b0;
        #1;
        chk("d64 load_valid", b64.load_valid, 1);
        chk("d64 load_data", b64.load_data, 64'h8123_4567_89AB_CDEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
